// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: RAM port status, arbiter FSM state, requester type codes.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Requester index r = 2*cpu + type
  localparam int ITYPE = 0;
  localparam int DTYPE = 1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of cache-requester and RAM-port signals around the arbiter.
// Latency: none (wiring only).
// Backpressure: requesters are held off through req_wait; the RAM stalls via ramstate.
interface ram_arbiter_if #(parameter int NCPU = 2);

  localparam int NREQ = 2 * NCPU;

  logic [NREQ-1:0]       req_ren;
  logic [NREQ-1:0]       req_wen;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ-1:0][31:0] req_addr;
  logic [NREQ-1:0][31:0] req_store;
  logic [NREQ-1:0]       req_wait;
  logic [31:0]           req_load;

  logic                         ramREN;
  logic                         ramWEN;
  logic [31:0]                  ramaddr;
  logic [31:0]                  ramstore;
  logic [31:0]                  ramload;
  ram_arbiter_pkg::ramstate_t   ramstate;

  // Arbiter side: serves the caches, drives the RAM
  modport slave (
    input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
    output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore
  );

  // Environment side: caches plus RAM
  modport master (
    output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping, as one-hot grant.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request is set.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [PW-1:0] idx;

  // Scan from ptr upward with wraparound and keep the first hit
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates icache/dcache word requests of NCPU cores onto one RAM port, with locked bursts.
// Latency: grant one cycle after a request is seen; word completes in the first ACCESS cycle.
// Backpressure: req_wait stays 1 until ACCESS; an unlocked word costs one idle turnaround cycle.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NCPU = 2
) (
  input  logic          CLK,
  input  logic          RST,
  ram_arbiter_if.slave  bus,
  output logic          err
);

  localparam int NREQ = 2 * NCPU;
  localparam int CW   = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int GW   = $clog2(NREQ);

  arb_state_t     state;
  logic [GW-1:0]  gidx;
  logic           gvld;
  logic [CW-1:0]  rr;

  logic [NREQ-1:0] wen_m;
  logic [NCPU-1:0] d_req, i_req, d_gnt, i_gnt;
  logic            d_vld, i_vld;
  logic [CW-1:0]   win_cpu;
  logic [GW-1:0]   win_idx;
  logic [CW-1:0]   next_rr;
  logic            g_ren, g_wen, g_lock, g_act, in_grant;

  // Icache slots cannot write; build per-class activity vectors
  always_comb begin
    wen_m = '0;
    d_req = '0;
    i_req = '0;
    for (int r = 0; r < NREQ; r++) begin
      if ((r % 2) == DTYPE) wen_m[r] = bus.req_wen[r];
    end
    for (int c = 0; c < NCPU; c++) begin
      d_req[c] = bus.req_ren[2*c + DTYPE] | wen_m[2*c + DTYPE];
      i_req[c] = bus.req_ren[2*c + ITYPE];
    end
  end

  rr_picker #(.N(NCPU), .PW(CW)) u_dpick (.req(d_req), .ptr(rr), .gnt(d_gnt), .vld(d_vld));
  rr_picker #(.N(NCPU), .PW(CW)) u_ipick (.req(i_req), .ptr(rr), .gnt(i_gnt), .vld(i_vld));

  // Dcache class wins outright; convert the class grant to a requester index
  always_comb begin
    win_cpu = '0;
    for (int c = 0; c < NCPU; c++) begin
      if (d_vld ? d_gnt[c] : i_gnt[c]) win_cpu = CW'(c);
    end
    win_idx = GW'(2 * int'(win_cpu) + (d_vld ? DTYPE : ITYPE));
    next_rr = CW'((int'(win_cpu) + 1) % NCPU);
  end

  assign g_ren    = bus.req_ren[gidx];
  assign g_wen    = wen_m[gidx];
  assign g_lock   = bus.req_lock[gidx];
  assign g_act    = g_ren | g_wen;
  assign in_grant = (state == GRANT) && gvld;

  // RAM port and requester returns follow the registered grant
  always_comb begin
    bus.ramWEN   = in_grant & g_wen;
    bus.ramREN   = in_grant & g_ren & ~g_wen;
    bus.ramaddr  = in_grant ? bus.req_addr[gidx]  : 32'h0;
    bus.ramstore = in_grant ? bus.req_store[gidx] : 32'h0;
    bus.req_load = bus.ramload;
    bus.req_wait = '1;
    if (in_grant && g_act && bus.ramstate == ACCESS) bus.req_wait[gidx] = 1'b0;
  end

  // Grant FSM: arbitrate in IDLE, hold the RAM in GRANT until release, lock or abort
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gidx  <= '0;
      gvld  <= 1'b0;
      rr    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_vld || i_vld) begin
            state <= GRANT;
            gidx  <= win_idx;
            gvld  <= 1'b1;
            rr    <= next_rr;
          end
        end
        GRANT: begin
          if (g_act && bus.ramstate == ERROR) err <= 1'b1;
          if (!g_act || (bus.ramstate == ACCESS && !g_lock)) begin
            state <= IDLE;
            gvld  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gvld  <= 1'b0;
        end
      endcase
    end
  end

endmodule
